cprv_hazard_unit: RTL and testbench

- Next-generation EX-stage operand forwarding and hazard unit for the cprv64g pipeline.
- Forwards results into NUM_RS source operands from MEM, from WB, and from the long-latency (mul/div) writeback port.
- Detects load-use hazards and keeps a per-register busy scoreboard for in-flight long-latency ops; raises a single stall to the ID/EX pipeline registers.
- Counts stall cycles for performance monitoring.

---
 rtl/cprv_hazard_unit_if.sv | 47 ++++
 rtl/cprv_hazard_unit.sv | 109 ++++++++++
 tb/tb_cprv_hazard_unit.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cprv_hazard_unit_if.sv
// Bundle between the cprv64g ID/EX/MEM/WB pipeline and the EX-stage hazard unit.
// The pipeline drives through master; the hazard unit attaches through slave.
interface cprv_hazard_unit_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_RS     = 2,
  parameter int CNT_WIDTH  = 32
);
  logic [5*NUM_RS-1:0]          rs_addr_ex;
  logic [NUM_RS-1:0]            rs_used_ex;
  logic [DATA_WIDTH*NUM_RS-1:0] rs_data_id_ex;
  logic [4:0]                   rd_addr_ex;
  logic                         rd_en_ex;
  logic                         long_issue_ex;
  logic                         flush_ex;
  logic [6:0]                   opcode_mem;
  logic [4:0]                   rd_addr_mem;
  logic                         rd_en_mem;
  logic [DATA_WIDTH-1:0]        alu_out_mem;
  logic [6:0]                   opcode_wb;
  logic [4:0]                   rd_addr_wb;
  logic                         rd_en_wb;
  logic [DATA_WIDTH-1:0]        alu_out_wb;
  logic [DATA_WIDTH-1:0]        mem_data_wb;
  logic                         long_wb_valid;
  logic [4:0]                   long_wb_rd;
  logic [DATA_WIDTH-1:0]        long_wb_data;
  logic [DATA_WIDTH*NUM_RS-1:0] rs_data_ex;
  logic                         stall;
  logic [31:0]                  busy_o;
  logic [CNT_WIDTH-1:0]         stall_cycles;

  modport master (
    output rs_addr_ex, rs_used_ex, rs_data_id_ex, rd_addr_ex, rd_en_ex,
           long_issue_ex, flush_ex, opcode_mem, rd_addr_mem, rd_en_mem,
           alu_out_mem, opcode_wb, rd_addr_wb, rd_en_wb, alu_out_wb,
           mem_data_wb, long_wb_valid, long_wb_rd, long_wb_data,
    input  rs_data_ex, stall, busy_o, stall_cycles
  );

  modport slave (
    input  rs_addr_ex, rs_used_ex, rs_data_id_ex, rd_addr_ex, rd_en_ex,
           long_issue_ex, flush_ex, opcode_mem, rd_addr_mem, rd_en_mem,
           alu_out_mem, opcode_wb, rd_addr_wb, rd_en_wb, alu_out_wb,
           mem_data_wb, long_wb_valid, long_wb_rd, long_wb_data,
    output rs_data_ex, stall, busy_o, stall_cycles
  );
endinterface

// File: rtl/cprv_hazard_unit.sv
// EX-stage operand forwarding, load-use / long-latency scoreboard stall
// generation and a saturating stall-cycle counter for the cprv64g pipeline.
module cprv_hazard_unit #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_RS     = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  cprv_hazard_unit_if.slave  hz
);
  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  logic [31:0]          busy_q;
  logic [31:0]          busy_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [NUM_RS-1:0]    load_use;
  logic [NUM_RS-1:0]    busy_hz;
  logic                 mem_is_load;
  logic                 wb_is_load;
  logic                 clr_en;
  logic                 set_en;
  logic                 waw;
  logic                 stall_raw;
  logic                 stall_int;

  assign mem_is_load = (hz.opcode_mem == OPC_LOAD);
  assign wb_is_load  = (hz.opcode_wb == OPC_LOAD);

  // Per-operand forwarding mux; priority order matters: MEM beats long-WB beats WB.
  for (genvar i = 0; i < NUM_RS; i++) begin : g_op
    logic [4:0]            rs;
    logic [DATA_WIDTH-1:0] id_val;
    logic                  mem_hit;
    logic                  long_hit;
    logic                  wb_hit;
    logic [DATA_WIDTH-1:0] fwd;

    assign rs       = hz.rs_addr_ex[5*i +: 5];
    assign id_val   = hz.rs_data_id_ex[DATA_WIDTH*i +: DATA_WIDTH];
    assign mem_hit  = hz.rd_en_mem && (rs == hz.rd_addr_mem);
    assign long_hit = hz.long_wb_valid && (rs == hz.long_wb_rd);
    assign wb_hit   = hz.rd_en_wb && (rs == hz.rd_addr_wb);

    always_comb begin
      fwd = id_val;
      if (rs == 5'd0) begin
        fwd = '0;
      end else if (mem_hit && !mem_is_load) begin
        fwd = hz.alu_out_mem;
      end else if (mem_hit) begin
        fwd = id_val;
      end else if (long_hit) begin
        fwd = hz.long_wb_data;
      end else if (wb_hit) begin
        fwd = wb_is_load ? hz.mem_data_wb : hz.alu_out_wb;
      end
    end

    assign hz.rs_data_ex[DATA_WIDTH*i +: DATA_WIDTH] = fwd;

    // A register being written back by the long unit this cycle is forwarded, so it is not a hazard.
    assign load_use[i] = (rs != 5'd0) && mem_hit && mem_is_load;
    assign busy_hz[i]  = busy_q[rs] && !long_hit;
  end

  assign clr_en = hz.long_wb_valid && (hz.long_wb_rd != 5'd0);

  assign waw = hz.rd_en_ex && (hz.rd_addr_ex != 5'd0) && busy_q[hz.rd_addr_ex]
               && !(clr_en && (hz.long_wb_rd == hz.rd_addr_ex));

  assign stall_raw = (|(hz.rs_used_ex & (load_use | busy_hz))) || waw;
  assign stall_int = stall_raw && !hz.flush_ex;

  assign set_en = hz.long_issue_ex && hz.rd_en_ex && (hz.rd_addr_ex != 5'd0)
                  && !stall_int && !hz.flush_ex;

  // Set is applied after clear so a same-register race keeps the younger op busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[hz.long_wb_rd] = 1'b0;
    end
    if (set_en) begin
      busy_d[hz.rd_addr_ex] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (stall_int && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hz.stall        = stall_int;
  assign hz.busy_o       = busy_q;
  assign hz.stall_cycles = cnt_q;
endmodule

// File: tb/tb_cprv_hazard_unit.sv
// Directed bench for cprv_hazard_unit; a second instance with a 4-bit counter
// mirrors the same stimulus to exercise counter saturation.
module tb_cprv_hazard_unit;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_OP   = 7'b0110011;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  cprv_hazard_unit_if #(.DATA_WIDTH(64), .NUM_RS(2), .CNT_WIDTH(32)) hz ();
  cprv_hazard_unit_if #(.DATA_WIDTH(64), .NUM_RS(2), .CNT_WIDTH(4))  hz4 ();

  cprv_hazard_unit #(.DATA_WIDTH(64), .NUM_RS(2), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .hz(hz.slave));
  cprv_hazard_unit #(.DATA_WIDTH(64), .NUM_RS(2), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .hz(hz4.slave));

  assign hz4.rs_addr_ex    = hz.rs_addr_ex;
  assign hz4.rs_used_ex    = hz.rs_used_ex;
  assign hz4.rs_data_id_ex = hz.rs_data_id_ex;
  assign hz4.rd_addr_ex    = hz.rd_addr_ex;
  assign hz4.rd_en_ex      = hz.rd_en_ex;
  assign hz4.long_issue_ex = hz.long_issue_ex;
  assign hz4.flush_ex      = hz.flush_ex;
  assign hz4.opcode_mem    = hz.opcode_mem;
  assign hz4.rd_addr_mem   = hz.rd_addr_mem;
  assign hz4.rd_en_mem     = hz.rd_en_mem;
  assign hz4.alu_out_mem   = hz.alu_out_mem;
  assign hz4.opcode_wb     = hz.opcode_wb;
  assign hz4.rd_addr_wb    = hz.rd_addr_wb;
  assign hz4.rd_en_wb      = hz.rd_en_wb;
  assign hz4.alu_out_wb    = hz.alu_out_wb;
  assign hz4.mem_data_wb   = hz.mem_data_wb;
  assign hz4.long_wb_valid = hz.long_wb_valid;
  assign hz4.long_wb_rd    = hz.long_wb_rd;
  assign hz4.long_wb_data  = hz.long_wb_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    hz.rs_addr_ex    = '0;
    hz.rs_used_ex    = '0;
    hz.rs_data_id_ex = {64'h1111, 64'h2222};
    hz.rd_addr_ex    = '0;
    hz.rd_en_ex      = 1'b0;
    hz.long_issue_ex = 1'b0;
    hz.flush_ex      = 1'b0;
    hz.opcode_mem    = OPC_OP;
    hz.rd_addr_mem   = '0;
    hz.rd_en_mem     = 1'b0;
    hz.alu_out_mem   = '0;
    hz.opcode_wb     = OPC_OP;
    hz.rd_addr_wb    = '0;
    hz.rd_en_wb      = 1'b0;
    hz.alu_out_wb    = '0;
    hz.mem_data_wb   = '0;
    hz.long_wb_valid = 1'b0;
    hz.long_wb_rd    = '0;
    hz.long_wb_data  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle();
    #1;
    chk("reset_busy", hz.busy_o, 64'h0);
    chk("reset_cnt", hz.stall_cycles, 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ALU result forwarded from MEM
    hz.rs_addr_ex  = {5'd0, 5'd5};
    hz.rs_used_ex  = 2'b01;
    hz.rd_en_mem   = 1'b1;
    hz.rd_addr_mem = 5'd5;
    hz.alu_out_mem = 64'h10;
    #1;
    chk("mem_fwd_op0", hz.rs_data_ex[63:0], 64'h10);
    chk("mem_fwd_op1_x0", hz.rs_data_ex[127:64], 64'h0);
    chk("mem_fwd_stall", {63'b0, hz.stall}, 64'h0);

    // MEM has priority over WB for the same register
    hz.rd_en_wb    = 1'b1;
    hz.rd_addr_wb  = 5'd5;
    hz.alu_out_wb  = 64'h20;
    hz.mem_data_wb = 64'h99;
    #1;
    chk("mem_over_wb", hz.rs_data_ex[63:0], 64'h10);

    hz.rd_en_mem = 1'b0;
    #1;
    chk("wb_alu_fwd", hz.rs_data_ex[63:0], 64'h20);
    hz.opcode_wb = OPC_LOAD;
    #1;
    chk("wb_load_fwd", hz.rs_data_ex[63:0], 64'h99);
    hz.rd_addr_wb = 5'd6;
    #1;
    chk("no_hit_regfile", hz.rs_data_ex[63:0], 64'h2222);
    tick();

    // Load-use on operand 1
    idle();
    hz.rs_addr_ex  = {5'd7, 5'd0};
    hz.rs_used_ex  = 2'b10;
    hz.rd_en_mem   = 1'b1;
    hz.rd_addr_mem = 5'd7;
    hz.opcode_mem  = OPC_LOAD;
    #1;
    chk("load_use_stall", {63'b0, hz.stall}, 64'h1);
    chk("load_use_cnt_before", hz.stall_cycles, 64'h0);
    tick();
    chk("load_use_cnt_after", hz.stall_cycles, 64'h1);
    hz.rs_used_ex = 2'b00;
    #1;
    chk("load_use_unused", {63'b0, hz.stall}, 64'h0);
    tick();
    chk("cnt_hold", hz.stall_cycles, 64'h1);

    // x0 is never forwarded nor a hazard
    idle();
    hz.rs_addr_ex  = {5'd0, 5'd0};
    hz.rs_used_ex  = 2'b11;
    hz.rd_en_mem   = 1'b1;
    hz.rd_addr_mem = 5'd0;
    hz.alu_out_mem = 64'hdead;
    #1;
    chk("x0_data", hz.rs_data_ex[63:0], 64'h0);
    chk("x0_stall", {63'b0, hz.stall}, 64'h0);
    hz.opcode_mem = OPC_LOAD;
    #1;
    chk("x0_load_stall", {63'b0, hz.stall}, 64'h0);
    tick();

    // Issue long op to x9
    idle();
    hz.long_issue_ex = 1'b1;
    hz.rd_en_ex      = 1'b1;
    hz.rd_addr_ex    = 5'd9;
    #1;
    chk("issue_no_stall", {63'b0, hz.stall}, 64'h0);
    tick();
    idle();
    #1;
    chk("busy9_set", hz.busy_o, 64'h200);

    hz.rs_addr_ex = {5'd0, 5'd9};
    hz.rs_used_ex = 2'b01;
    #1;
    chk("busy_read_stall", {63'b0, hz.stall}, 64'h1);
    tick();
    tick();
    chk("busy_read_stall2", {63'b0, hz.stall}, 64'h1);
    chk("busy_cnt", hz.stall_cycles, 64'h3);
    hz.long_wb_valid = 1'b1;
    hz.long_wb_rd    = 5'd9;
    hz.long_wb_data  = 64'h2A;
    #1;
    chk("wb_bypass_stall", {63'b0, hz.stall}, 64'h0);
    chk("wb_bypass_data", hz.rs_data_ex[63:0], 64'h2A);
    tick();
    idle();
    #1;
    chk("busy9_clear", hz.busy_o, 64'h0);
    chk("cnt_after_clear", hz.stall_cycles, 64'h3);

    // Set/clear race on the same register
    hz.long_issue_ex = 1'b1;
    hz.rd_en_ex      = 1'b1;
    hz.rd_addr_ex    = 5'd9;
    tick();
    #1;
    chk("busy9_again", hz.busy_o, 64'h200);
    hz.long_wb_valid = 1'b1;
    hz.long_wb_rd    = 5'd9;
    #1;
    chk("race_no_waw", {63'b0, hz.stall}, 64'h0);
    tick();
    chk("race_set_wins", hz.busy_o, 64'h200);

    // Clear x9 while issuing to x3
    hz.rd_addr_ex = 5'd3;
    tick();
    idle();
    #1;
    chk("indep_set_clear", hz.busy_o, 64'h8);

    // WAW against busy x3, then flushed
    hz.rd_en_ex   = 1'b1;
    hz.rd_addr_ex = 5'd3;
    #1;
    chk("waw_stall", {63'b0, hz.stall}, 64'h1);
    hz.flush_ex = 1'b1;
    #1;
    chk("waw_flush", {63'b0, hz.stall}, 64'h0);
    hz.long_issue_ex = 1'b1;
    hz.rd_addr_ex    = 5'd4;
    tick();
    idle();
    #1;
    chk("flush_no_set", hz.busy_o, 64'h8);
    chk("cnt_after_flush", hz.stall_cycles, 64'h3);

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", hz.busy_o, 64'h0);
    chk("async_rst_cnt", hz.stall_cycles, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Saturation: 20 load-use stall cycles
    hz.rs_addr_ex  = {5'd0, 5'd7};
    hz.rs_used_ex  = 2'b01;
    hz.rd_en_mem   = 1'b1;
    hz.rd_addr_mem = 5'd7;
    hz.opcode_mem  = OPC_LOAD;
    repeat (20) tick();
    chk("sat_cnt4", {60'b0, hz4.stall_cycles}, 64'hF);
    chk("cnt32_20", hz.stall_cycles, 64'd20);
    idle();
    tick();
    chk("sat_cnt4_hold", {60'b0, hz4.stall_cycles}, 64'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
